// File: rtl/snp_req_handler.sv
// snp_req_handler
//   Snoop-request controller for the MESI L1 cache. It accepts one snoop
//   (op + address) at a time and locks the shared tag/state/data array. It
//   then looks up all ways of the indexed set and writes the selected way's
//   new MESI state back while the array is still locked. Finally it returns a
//   response, carrying the line data when the line was MODIFIED.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   snp_req_valid/ready/op/addr  incoming snoop request handshake
//   arr_req, arr_gnt             array lock request / grant from arbiter
//   arr_rd_en, arr_rd_idx        array read strobe and set index
//   arr_rd_tag/st/data           per-way tag, state, data (cycle after rd_en)
//   arr_wr_en/idx/way/st         state write-back
//   snp_rsp_valid/ready          response handshake
//   snp_rsp, snp_rsp_has_data,
//   snp_rsp_data                 response code and optional dirty line
//   snp_hit_cnt                  saturating snoop-hit counter
//   err_multi_hit                sticky flag: more than one valid way matched
module snp_req_handler #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int NUM_SETS   = 256,
  parameter  int NUM_WAYS   = 4,
  parameter  int LINE_BYTES = 64,
  parameter  int CNT_WIDTH  = 16,
  localparam int IDX_W      = $clog2(NUM_SETS),
  localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int OFF_W      = $clog2(LINE_BYTES),
  localparam int DATA_WIDTH = LINE_BYTES * 8,
  localparam int TAG_W      = ADDR_WIDTH - IDX_W - OFF_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           snp_req_valid,
  output logic                           snp_req_ready,
  input  logic [1:0]                     snp_req_op,
  input  logic [ADDR_WIDTH-1:0]          snp_req_addr,
  output logic                           arr_req,
  input  logic                           arr_gnt,
  output logic                           arr_rd_en,
  output logic [IDX_W-1:0]               arr_rd_idx,
  input  logic [NUM_WAYS*TAG_W-1:0]      arr_rd_tag,
  input  logic [NUM_WAYS*3-1:0]          arr_rd_st,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] arr_rd_data,
  output logic                           arr_wr_en,
  output logic [IDX_W-1:0]               arr_wr_idx,
  output logic [WAY_W-1:0]               arr_wr_way,
  output logic [2:0]                     arr_wr_st,
  output logic                           snp_rsp_valid,
  input  logic                           snp_rsp_ready,
  output logic [1:0]                     snp_rsp,
  output logic                           snp_rsp_has_data,
  output logic [DATA_WIDTH-1:0]          snp_rsp_data,
  output logic [CNT_WIDTH-1:0]           snp_hit_cnt,
  output logic                           err_multi_hit
);

  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_S = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;

  localparam logic [1:0] SUREQ_RD   = 2'd0;
  localparam logic [1:0] SUREQ_RFO  = 2'd1;
  localparam logic [1:0] SUREQ_INV  = 2'd2;
  localparam logic [1:0] SUREQ_RSVD = 2'd3;

  localparam logic [1:0] SDRSP_OKAY = 2'd0;
  localparam logic [1:0] SDRSP_INV  = 2'd1;

  typedef enum logic [1:0] {IDLE, ARB, LOOKUP, RSP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              rsp_q;
  logic                    has_data_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [CNT_WIDTH-1:0]    hit_cnt_q;
  logic                    multi_hit_q;

  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [NUM_WAYS-1:0]     hit_vec;
  logic                    hit_any;
  logic                    multi_hit;
  logic                    lookup_hit;
  logic [WAY_W-1:0]        sel_way;
  logic [2:0]              cur_st;
  logic [2:0]              nxt_st;
  logic                    nxt_has_data;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign req_idx = addr_q[OFF_W +: IDX_W];
  assign req_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];

  // Tag match across all ways. The descending scan leaves the lowest-index
  // hit as the selected way. x & (x-1) is non-zero when two or more bits are set.
  always_comb begin
    hit_vec  = '0;
    sel_way  = '0;
    cur_st   = ST_I;
    sel_data = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = (arr_rd_st[w*3 +: 3] != ST_I) &&
                   (arr_rd_tag[w*TAG_W +: TAG_W] == req_tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        sel_way  = WAY_W'(w);
        cur_st   = arr_rd_st[w*3 +: 3];
        sel_data = arr_rd_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    hit_any    = |hit_vec;
    multi_hit  = (hit_vec & (hit_vec - NUM_WAYS'(1))) != '0;
    lookup_hit = hit_any && (op_q != SUREQ_RSVD);
  end

  // MESI transition for the selected way. Undefined state encodings are left
  // untouched so no write is issued for them.
  always_comb begin
    nxt_st       = cur_st;
    nxt_has_data = 1'b0;
    if (cur_st == ST_M || cur_st == ST_E || cur_st == ST_S) begin
      nxt_has_data = (cur_st == ST_M);
      unique case (op_q)
        SUREQ_RD:  nxt_st = ST_S;
        SUREQ_RFO,
        SUREQ_INV: nxt_st = ST_I;
        default:   nxt_st = cur_st;
      endcase
    end
  end

  // Next-state and handshake/array outputs. arr_req stays high through LOOKUP
  // so the state write-back cannot be interleaved with another array user.
  always_comb begin
    state_d       = state_q;
    snp_req_ready = 1'b0;
    arr_req       = 1'b0;
    arr_rd_en     = 1'b0;
    arr_rd_idx    = '0;
    arr_wr_en     = 1'b0;
    arr_wr_idx    = '0;
    arr_wr_way    = '0;
    arr_wr_st     = '0;
    snp_rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        snp_req_ready = 1'b1;
        if (snp_req_valid) state_d = ARB;
      end
      ARB: begin
        arr_req    = 1'b1;
        arr_rd_en  = arr_gnt;
        arr_rd_idx = req_idx;
        if (arr_gnt) state_d = LOOKUP;
      end
      LOOKUP: begin
        arr_req = 1'b1;
        if (lookup_hit && (nxt_st != cur_st)) begin
          arr_wr_en  = 1'b1;
          arr_wr_idx = req_idx;
          arr_wr_way = sel_way;
          arr_wr_st  = nxt_st;
        end
        state_d = RSP;
      end
      RSP: begin
        snp_rsp_valid = 1'b1;
        if (snp_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request latch, registered response, hit statistics and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      addr_q      <= '0;
      rsp_q       <= '0;
      has_data_q  <= 1'b0;
      data_q      <= '0;
      hit_cnt_q   <= '0;
      multi_hit_q <= 1'b0;
    end else begin
      if (state_q == IDLE && snp_req_valid) begin
        op_q   <= snp_req_op;
        addr_q <= snp_req_addr;
      end
      if (state_q == LOOKUP) begin
        rsp_q      <= lookup_hit ? SDRSP_OKAY : SDRSP_INV;
        has_data_q <= lookup_hit && nxt_has_data;
        data_q     <= (lookup_hit && nxt_has_data) ? sel_data : '0;
        if (lookup_hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 1'b1;
        if (multi_hit) multi_hit_q <= 1'b1;
      end
    end
  end

  assign snp_rsp          = rsp_q;
  assign snp_rsp_has_data = has_data_q;
  assign snp_rsp_data     = data_q;
  assign snp_hit_cnt      = hit_cnt_q;
  assign err_multi_hit    = multi_hit_q;

endmodule

// File: tb/tb_snp_req_handler.sv
// Directed bench for snp_req_handler with a response scoreboard. It uses a
// small configuration: 16-bit address, 16 sets, 4 ways, 4-byte lines and a
// 2-bit hit counter, so counter saturation is reachable.
module tb_snp_req_handler;

  localparam int AW = 16;
  localparam int NS = 16;
  localparam int NW = 4;
  localparam int LB = 4;
  localparam int CW = 2;
  localparam int TW = 10;
  localparam int DW = 32;

  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_S = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [1:0] OP_RD = 2'd0, OP_RFO = 2'd1, OP_INV = 2'd2, OP_RSVD = 2'd3;
  localparam logic [1:0] RSP_OKAY = 2'd0, RSP_INV = 2'd1;

  typedef struct {
    logic [1:0]    rsp;
    logic          hd;
    logic [DW-1:0] data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              snp_req_valid = 1'b0;
  logic              snp_req_ready;
  logic [1:0]        snp_req_op = '0;
  logic [AW-1:0]     snp_req_addr = '0;
  logic              arr_req;
  logic              arr_gnt = 1'b0;
  logic              arr_rd_en;
  logic [3:0]        arr_rd_idx;
  logic [NW*TW-1:0]  arr_rd_tag = '0;
  logic [NW*3-1:0]   arr_rd_st = '0;
  logic [NW*DW-1:0]  arr_rd_data = '0;
  logic              arr_wr_en;
  logic [3:0]        arr_wr_idx;
  logic [1:0]        arr_wr_way;
  logic [2:0]        arr_wr_st;
  logic              snp_rsp_valid;
  logic              snp_rsp_ready = 1'b0;
  logic [1:0]        snp_rsp;
  logic              snp_rsp_has_data;
  logic [DW-1:0]     snp_rsp_data;
  logic [CW-1:0]     snp_hit_cnt;
  logic              err_multi_hit;

  int   assertCnt = 0;
  int   failCnt   = 0;
  int   cycleCnt  = 0;
  int   modelCnt  = 0;
  logic modelErr  = 1'b0;
  rsp_t sbQ[$];

  logic [TW-1:0] setTag[NW];
  logic [2:0]    setSt[NW];
  logic [DW-1:0] setData[NW];

  snp_req_handler #(
    .ADDR_WIDTH(AW), .NUM_SETS(NS), .NUM_WAYS(NW), .LINE_BYTES(LB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
    .snp_req_op(snp_req_op), .snp_req_addr(snp_req_addr),
    .arr_req(arr_req), .arr_gnt(arr_gnt),
    .arr_rd_en(arr_rd_en), .arr_rd_idx(arr_rd_idx),
    .arr_rd_tag(arr_rd_tag), .arr_rd_st(arr_rd_st), .arr_rd_data(arr_rd_data),
    .arr_wr_en(arr_wr_en), .arr_wr_idx(arr_wr_idx), .arr_wr_way(arr_wr_way),
    .arr_wr_st(arr_wr_st),
    .snp_rsp_valid(snp_rsp_valid), .snp_rsp_ready(snp_rsp_ready),
    .snp_rsp(snp_rsp), .snp_rsp_has_data(snp_rsp_has_data), .snp_rsp_data(snp_rsp_data),
    .snp_hit_cnt(snp_hit_cnt), .err_multi_hit(err_multi_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setWay(input int w, input logic [TW-1:0] t, input logic [2:0] s,
                        input logic [DW-1:0] d);
    setTag[w]  = t;
    setSt[w]   = s;
    setData[w] = d;
  endtask

  // Outside the lookup cycle the read bus carries decoy lines that all match
  // the request tag as MODIFIED, so sampling at the wrong time shows up.
  task automatic driveReadBus(input bit live, input logic [TW-1:0] reqTag);
    for (int w = 0; w < NW; w++) begin
      arr_rd_tag[w*TW +: TW] = live ? setTag[w]  : reqTag;
      arr_rd_st[w*3 +: 3]    = live ? setSt[w]   : ST_M;
      arr_rd_data[w*DW +: DW] = live ? setData[w] : (32'hBAD0_0000 | 32'(w));
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [TW-1:0] tag,
                               input logic [3:0] idx, input int gntDelay, input int rspHold,
                               input bit expWr, input logic [1:0] expWay,
                               input logic [2:0] expSt, input logic [1:0] expRsp,
                               input bit expHd, input logic [DW-1:0] expData);
    rsp_t e;
    int   t0;
    e = '{expRsp, expHd, expData};
    sbQ.push_back(e);
    if (expRsp == RSP_OKAY && modelCnt != 3) modelCnt++;
    driveReadBus(0, tag);
    snp_req_valid = 1'b1;
    snp_req_op    = op;
    snp_req_addr  = {tag, idx, 2'b01};
    #1 check("req_ready_idle", snp_req_ready, 1);
    t0 = cycleCnt;
    @(negedge clk);
    snp_req_valid = 1'b0;
    snp_req_op    = '0;
    snp_req_addr  = '0;
    for (int i = 0; i < gntDelay; i++) begin
      arr_gnt = 1'b0;
      #1;
      check("arb_req_held", arr_req, 1);
      check("arb_no_rd_en", arr_rd_en, 0);
      check("busy_not_ready", snp_req_ready, 0);
      @(negedge clk);
    end
    arr_gnt = 1'b1;
    #1;
    check("arb_rd_en", arr_rd_en, 1);
    check("arb_rd_idx", arr_rd_idx, idx);
    @(negedge clk);
    arr_gnt = 1'b0;
    driveReadBus(1, tag);
    #1;
    check("lookup_arr_req", arr_req, 1);
    check("lookup_rd_en_off", arr_rd_en, 0);
    check("lookup_wr_en", arr_wr_en, expWr);
    if (expWr) begin
      check("lookup_wr_idx", arr_wr_idx, idx);
      check("lookup_wr_way", arr_wr_way, expWay);
      check("lookup_wr_st", arr_wr_st, expSt);
    end
    @(negedge clk);
    driveReadBus(0, tag);
    #1;
    check("rsp_valid", snp_rsp_valid, 1);
    check("rsp_latency", cycleCnt - t0, 3 + gntDelay);
    check("rsp_no_wr", arr_wr_en, 0);
    for (int i = 0; i < rspHold; i++) begin
      check("hold_rsp", snp_rsp, sbQ[0].rsp);
      check("hold_has_data", snp_rsp_has_data, sbQ[0].hd);
      check("hold_data", snp_rsp_data, sbQ[0].data);
      check("hold_not_ready", snp_req_ready, 0);
      @(negedge clk);
      #1 check("hold_valid", snp_rsp_valid, 1);
    end
    snp_rsp_ready = 1'b1;
    e = sbQ.pop_front();
    check("rsp_code", snp_rsp, e.rsp);
    check("rsp_has_data", snp_rsp_has_data, e.hd);
    check("rsp_data", snp_rsp_data, e.data);
    check("handshake_not_ready", snp_req_ready, 0);
    @(negedge clk);
    snp_rsp_ready = 1'b0;
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    check("idle_rsp_valid", snp_rsp_valid, 0);
    check("idle_req_ready", snp_req_ready, 1);
    check("idle_arr_req", arr_req, 0);
    check("hit_cnt", snp_hit_cnt, modelCnt);
    check("err_multi_hit", err_multi_hit, modelErr);
  endtask

  initial begin
    for (int w = 0; w < NW; w++) setWay(w, '0, ST_I, '0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_req_ready", snp_req_ready, 1);
    check("reset_arr_rd_en", arr_rd_en, 0);
    check("reset_arr_wr_en", arr_wr_en, 0);
    checkOutput();
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while in LOOKUP abandons the transaction.
    setWay(0, 10'h111, ST_M, 32'hA000_0000);
    setWay(1, 10'h2A5, ST_I, 32'hA111_1111);
    setWay(2, 10'h2A5, ST_M, 32'hA222_2222);
    setWay(3, 10'h3FF, ST_S, 32'hA333_3333);
    snp_req_valid = 1'b1;
    snp_req_op    = OP_RD;
    snp_req_addr  = {10'h2A5, 4'd5, 2'b00};
    @(negedge clk);
    snp_req_valid = 1'b0;
    arr_gnt = 1'b1;
    @(negedge clk);
    arr_gnt = 1'b0;
    driveReadBus(1, 10'h2A5);
    #1 check("pre_reset_wr_en", arr_wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("midop_wr_en", arr_wr_en, 0);
    check("midop_req_ready", snp_req_ready, 1);
    check("midop_hit_cnt", snp_hit_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("midop_no_rsp", snp_rsp_valid, 0);
    end

    // RD hit on MODIFIED way 2 (way 1 matches tag but is INVALID).
    applyStimulus(OP_RD, 10'h2A5, 4'd5, 0, 0, 1, 2'd2, ST_S, RSP_OKAY, 1, 32'hA222_2222);

    // RFO hit on EXCLUSIVE way 0 with a 4-cycle grant delay.
    setWay(0, 10'h155, ST_E, 32'hB000_0000);
    setWay(1, 10'h156, ST_M, 32'hB111_1111);
    setWay(2, 10'h157, ST_S, 32'hB222_2222);
    setWay(3, 10'h158, ST_E, 32'hB333_3333);
    applyStimulus(OP_RFO, 10'h155, 4'd9, 4, 0, 1, 2'd0, ST_I, RSP_OKAY, 0, 32'h0);

    // INV to a set whose ways all carry the tag but are INVALID.
    for (int w = 0; w < NW; w++) setWay(w, 10'h155, ST_I, 32'hC000_0000 | 32'(w));
    applyStimulus(OP_INV, 10'h155, 4'd3, 0, 0, 0, 2'd0, ST_I, RSP_INV, 0, 32'h0);

    // Reserved op on a MODIFIED matching line is a miss.
    setWay(0, 10'h0F0, ST_M, 32'hD000_0000);
    applyStimulus(OP_RSVD, 10'h0F0, 4'd7, 1, 0, 0, 2'd0, ST_I, RSP_INV, 0, 32'h0);

    // RD hit on SHARED way 3: no write, no data.
    setWay(0, 10'h001, ST_M, 32'hE000_0000);
    setWay(1, 10'h002, ST_E, 32'hE111_1111);
    setWay(2, 10'h003, ST_S, 32'hE222_2222);
    setWay(3, 10'h0AB, ST_S, 32'hE333_3333);
    applyStimulus(OP_RD, 10'h0AB, 4'd12, 0, 0, 0, 2'd0, ST_I, RSP_OKAY, 0, 32'h0);

    // RFO hit on MODIFIED way 1 with 3 cycles of response backpressure.
    setWay(1, 10'h3C3, ST_M, 32'hF111_1111);
    applyStimulus(OP_RFO, 10'h3C3, 4'd15, 0, 3, 1, 2'd1, ST_I, RSP_OKAY, 1, 32'hF111_1111);

    // Ways 1 and 3 both match: lowest way wins and the error flag sets.
    setWay(0, 10'h200, ST_M, 32'h1000_0000);
    setWay(1, 10'h077, ST_E, 32'h1111_1111);
    setWay(2, 10'h201, ST_S, 32'h1222_2222);
    setWay(3, 10'h077, ST_M, 32'h1333_3333);
    modelErr = 1'b1;
    applyStimulus(OP_RD, 10'h077, 4'd2, 0, 0, 1, 2'd1, ST_S, RSP_OKAY, 0, 32'h0);

    // Single-hit INV on SHARED; error flag stays set, counter saturated.
    setWay(0, 10'h099, ST_S, 32'h2000_0000);
    setWay(3, 10'h098, ST_M, 32'h2333_3333);
    applyStimulus(OP_INV, 10'h099, 4'd8, 2, 1, 1, 2'd0, ST_I, RSP_OKAY, 0, 32'h0);

    check("sb_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/snp_req_handler.md
Name: snp_req_handler

Overview:
- Sequential, parametrised snoop-request controller for the MESI L1 cache.
- Accepts one snoop request (op + address) from the snoop bus, arbitrates for the tag/state/data array and performs an N-way tag lookup.
- Computes each way's MESI next state, writes the state back atomically, and returns a response, with line data when the line was MODIFIED.
- Sits between the snoop bus interface and the shared cache array arbiter.

Parameters:
ADDR_WIDTH, 32, snoop address width
NUM_SETS, 256, sets in array (power of 2); IDX_W = log2(NUM_SETS)
NUM_WAYS, 4, associativity (power of 2, >=1); WAY_W = max(1, log2(NUM_WAYS))
LINE_BYTES, 64, line size (power of 2); OFF_W = log2(LINE_BYTES), DATA_WIDTH = LINE_BYTES*8
CNT_WIDTH, 16, width of snoop-hit statistics counter
Derived: TAG_W = ADDR_WIDTH - IDX_W - OFF_W

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
snp_req_valid  in  1  snoop request valid
snp_req_ready  out  1  handler can accept request
snp_req_op  in  2  SUREQ_RD / SUREQ_RFO / SUREQ_INV; 2'b11 reserved
snp_req_addr  in  ADDR_WIDTH  snooped address
arr_req  out  1  request/lock of cache array
arr_gnt  in  1  array grant from arbiter
arr_rd_en  out  1  array read strobe
arr_rd_idx  out  IDX_W  read set index
arr_rd_tag  in  NUM_WAYS*TAG_W  per-way tags, valid cycle after arr_rd_en
arr_rd_st  in  NUM_WAYS*3  per-way MESI state, same timing
arr_rd_data  in  NUM_WAYS*DATA_WIDTH  per-way line data, same timing
arr_wr_en  out  1  state write strobe
arr_wr_idx  out  IDX_W  write set
arr_wr_way  out  WAY_W  write way
arr_wr_st  out  3  new state
snp_rsp_valid  out  1  response valid
snp_rsp_ready  in  1  response accepted
snp_rsp  out  2  SDRSP_OKAY (hit) / SDRSP_INV (miss)
snp_rsp_has_data  out  1  snp_rsp_data carries dirty line
snp_rsp_data  out  DATA_WIDTH  line data (zero when has_data=0)
snp_hit_cnt  out  CNT_WIDTH  saturating count of snoop hits
err_multi_hit  out  1  sticky: >1 way matched valid tag

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. All outputs 0 except snp_req_ready=1. snp_hit_cnt, err_multi_hit, and all latched op/addr/response registers cleared. Reset mid-operation abandons the transaction: no array write, no response.
- Address split: idx = addr[OFF_W +: IDX_W]; tag = addr[ADDR_WIDTH-1 -: TAG_W]; offset ignored.
- FSM states: IDLE, ARB, LOOKUP, RSP.
- IDLE: snp_req_ready=1. On valid&ready, latch op/addr and go to ARB.
- ARB: arr_req=1. arr_rd_en=arr_gnt, arr_rd_idx=latched idx. On arr_gnt go to LOOKUP; otherwise stay.
- LOOKUP (one cycle): arr_req stays 1, holding the array so read-modify-write is atomic.
  - hit[w] = (st[w]!=INVALID) && (tag[w]==latched tag). Lowest-index hit way selected.
  - More than one hit sets err_multi_hit (sticky until reset).
  - Next state computed for the selected way; arr_wr_en=1 in this cycle only if hit && nxt!=cur, with idx/way/st driven.
  - Response registered, FSM goes to RSP.
- Next-state table (hit way), with has_data in brackets:
  - RD: M->S[1], E->S[0], S->S[0].
  - RFO: M->I[1], E->I[0], S->I[0].
  - INV: M->I[1], E->I[0], S->I[0].
  - Miss: no write, SDRSP_INV, has_data=0.
  - Reserved op 2'b11: treated as miss regardless of tags (no write, no count).
- Response: snp_rsp=SDRSP_OKAY on hit, else SDRSP_INV. snp_rsp_data = selected way's data when has_data=1, else 0.
- RSP: snp_rsp_valid=1. snp_rsp, has_data and data are stable until snp_rsp_valid&snp_rsp_ready, then go to IDLE. A new request is not accepted in the handshake cycle; earliest acceptance is the next cycle.
- snp_hit_cnt increments by 1 in the LOOKUP cycle on a hit (legal op), saturating at all-ones.
- Latency: accept (cycle 0) -> ARB (1, grant same cycle) -> LOOKUP (2) -> snp_rsp_valid (3). Each cycle of arr_gnt=0 in ARB adds one cycle.
- Only one transaction in flight; snp_req_ready=0 outside IDLE.

Test Plan:
- Reset mid-op: assert rst_n=0 in LOOKUP -> arr_wr_en=0 immediately, snp_rsp_valid never rises, snp_req_ready=1, snp_hit_cnt=0.
- RD hit on MODIFIED, way 2, gnt immediate: idx=5, tag match -> arr_wr_en in cycle 2 with way=2, st=SHARED; cycle 3 snp_rsp=SDRSP_OKAY, has_data=1, data=way-2 line; snp_hit_cnt=1.
- RFO hit on EXCLUSIVE, gnt delayed 4 cycles: arr_req held 4 cycles, arr_rd_en pulses once -> write st=INVALID, has_data=0, rsp_valid at cycle 7.
- RD on SHARED hit -> no arr_wr_en, SDRSP_OKAY. Then INV to an all-INVALID set -> SDRSP_INV, no write, counter unchanged.
- Backpressure and reserved op: snp_rsp_ready=0 for 3 cycles -> response fields constant, snp_req_ready=0. Then op=2'b11 on a matching tag -> SDRSP_INV, no write, counter unchanged.
- Multi-hit and saturation: ways 1 and 3 both match -> way 1 written, err_multi_hit=1 sticky. With CNT_WIDTH=2, 5 hits -> snp_hit_cnt=3.
